// File: rtl/w5500_pkg.sv
// Shared types and constants for the W5500 UDP receive path.
package w5500_pkg;

  localparam int unsigned W5500_UDP_HDR_BYTES = 8;
  localparam int unsigned WORD_BYTES          = 6;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    BADLEN   = 2'd1,
    SHORT    = 2'd2,
    LONG     = 2'd3
  } err_code_t;

endpackage

// File: rtl/w5500_byte_packer.sv
// Packs payload bytes MSB-first into 48-bit words; the assembly and output registers form a skid.
module w5500_byte_packer
  import w5500_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        word_ready,
  output logic        in_ready,
  output logic        last_slot,
  output logic        word_done,
  output logic [47:0] word_out,
  output logic        word_valid
);

  localparam logic [2:0] LastIdx = 3'(WORD_BYTES - 1);

  logic [39:0] asm_q, asm_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] out_q, out_d;
  logic        valid_q, valid_d;

  assign last_slot  = (idx_q == LastIdx);
  assign word_done  = push && last_slot;
  // Only a word-completing byte needs the output register free.
  assign in_ready   = !(valid_q && !word_ready && last_slot);
  assign word_out   = out_q;
  assign word_valid = valid_q;

  always_comb begin
    asm_d   = asm_q;
    idx_d   = idx_q;
    out_d   = out_q;
    valid_d = valid_q;
    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    if (push) begin
      if (last_slot) begin
        out_d   = {asm_q, byte_in};
        valid_d = 1'b1;
        idx_d   = 3'd0;
      end else begin
        asm_d = {asm_q[31:0], byte_in};
        idx_d = idx_q + 3'd1;
      end
    end
    if (clear) begin
      idx_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/w5500_udp_rx_unpacker.sv
// Strips the W5500 UDP RX header, validates the length and emits 48-bit payload words.
module w5500_udp_rx_unpacker
  import w5500_pkg::*;
#(
  parameter int unsigned LENGTH_UDP = 245
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  output logic        rx_ready,
  output logic [47:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] pkt_len,
  output logic        hdr_valid,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [1:0]  err_code
);

  localparam int unsigned MaxLen  = LENGTH_UDP * WORD_BYTES;
  localparam logic [2:0]  HdrLast = 3'(W5500_UDP_HDR_BYTES - 1);

  rx_state_t   state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [55:0] hdr_q, hdr_d;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q, pkt_len_q;
  logic [8:0]  words_exp_q, word_cnt_q;
  logic        hdr_valid_q, pkt_done_q, pkt_err_q;
  err_code_t   err_code_q;

  logic        accept, latch_hdr, push, clear, done_set, err_set;
  logic        last_slot, word_done, pay_last, len_bad;
  logic [15:0] hdr_len;
  err_code_t   err_new;

  assign accept  = rx_valid && rx_ready;
  assign hdr_len = {hdr_q[7:0], rx_byte};
  assign len_bad = (hdr_len == 16'd0) || (hdr_len % 16'(WORD_BYTES) != 16'd0) ||
                   (32'(hdr_len) > MaxLen);
  // Length is a whole number of words, so the packet ends exactly on a word boundary.
  assign pay_last = (word_cnt_q == words_exp_q - 9'd1) && last_slot;
  assign clear    = accept && (state_d != PAYLOAD);

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_d     = hdr_q;
    latch_hdr = 1'b0;
    push      = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    err_new   = ERR_NONE;
    if (accept) begin
      if (rx_sop) begin
        // A start-of-packet always restarts header collection, whatever was in flight.
        hdr_d     = {hdr_q[47:0], rx_byte};
        hdr_cnt_d = 3'd1;
        state_d   = rx_eop ? IDLE : HDR;
        if (state_q == HDR || state_q == PAYLOAD || rx_eop) begin
          err_set = 1'b1;
          err_new = SHORT;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          HDR: begin
            hdr_d = {hdr_q[47:0], rx_byte};
            if (hdr_cnt_q == HdrLast) begin
              latch_hdr = 1'b1;
              if (len_bad) begin
                err_set = 1'b1;
                err_new = BADLEN;
                state_d = rx_eop ? IDLE : DROP;
              end else if (rx_eop) begin
                err_set = 1'b1;
                err_new = SHORT;
                state_d = IDLE;
              end else begin
                state_d = PAYLOAD;
              end
            end else if (rx_eop) begin
              err_set = 1'b1;
              err_new = SHORT;
              state_d = IDLE;
            end else begin
              hdr_cnt_d = hdr_cnt_q + 3'd1;
            end
          end
          PAYLOAD: begin
            push = 1'b1;
            if (pay_last) begin
              if (rx_eop) begin
                done_set = 1'b1;
                state_d  = IDLE;
              end else begin
                err_set = 1'b1;
                err_new = LONG;
                state_d = DROP;
              end
            end else if (rx_eop) begin
              err_set = 1'b1;
              err_new = SHORT;
              state_d = IDLE;
            end
          end
          DROP: begin
            if (rx_eop) begin
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= '0;
      hdr_q       <= '0;
      src_ip_q    <= '0;
      src_port_q  <= '0;
      pkt_len_q   <= '0;
      words_exp_q <= '0;
      word_cnt_q  <= '0;
      hdr_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= latch_hdr;
      pkt_done_q  <= done_set;
      pkt_err_q   <= err_set;
      if (err_set) begin
        err_code_q <= err_new;
      end
      if (latch_hdr) begin
        src_ip_q    <= hdr_q[55:24];
        src_port_q  <= hdr_q[23:8];
        pkt_len_q   <= hdr_len;
        words_exp_q <= 9'(hdr_len / 16'(WORD_BYTES));
        word_cnt_q  <= '0;
      end else if (word_done) begin
        word_cnt_q <= word_cnt_q + 9'd1;
      end
    end
  end

  w5500_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .clear      (clear),
    .byte_in    (rx_byte),
    .word_ready (word_ready),
    .in_ready   (rx_ready),
    .last_slot  (last_slot),
    .word_done  (word_done),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  assign src_ip    = src_ip_q;
  assign src_port  = src_port_q;
  assign pkt_len   = pkt_len_q;
  assign hdr_valid = hdr_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_w5500_udp_rx_unpacker.sv
// Directed bench for w5500_udp_rx_unpacker: header decode, packing, backpressure and error paths.
module tb_w5500_udp_rx_unpacker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_sop, rx_eop, rx_ready;
  logic [47:0] word_out;
  logic        word_valid, word_ready;
  logic [31:0] src_ip;
  logic [15:0] src_port, pkt_len;
  logic        hdr_valid, pkt_done, pkt_err;
  logic [1:0]  err_code;

  always #10 clk = ~clk;

  w5500_udp_rx_unpacker #(.LENGTH_UDP(245)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .rx_ready   (rx_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .src_ip     (src_ip),
    .src_port   (src_port),
    .pkt_len    (pkt_len),
    .hdr_valid  (hdr_valid),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .err_code   (err_code)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       s;
    logic       e;
  } sb_t;

  sb_t         stim[$];
  logic [47:0] rx_words[$];
  logic [47:0] exp_words[$];
  int n_total = 0, n_bad = 0;
  int n_done = 0, n_err = 0, n_hdr = 0, n_both = 0, n_stall0c = 0;
  int base_w, base_d, base_e, base_h, base_s;
  bit gaps = 1'b0;

  // Observe transfers and pulses once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (word_valid && word_ready) rx_words.push_back(word_out);
    if (pkt_done) n_done++;
    if (pkt_err) n_err++;
    if (pkt_done && pkt_err) n_both++;
    if (hdr_valid) n_hdr++;
    if (rx_valid && !rx_ready && rx_byte == 8'h0C) n_stall0c++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base_w = rx_words.size();
    base_d = n_done;
    base_e = n_err;
    base_h = n_hdr;
    base_s = n_stall0c;
  endtask

  task automatic drive(input logic [7:0] b, input logic s, input logic e);
    int w;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rx_byte  = b;
    rx_sop   = s;
    rx_eop   = e;
    rx_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!rx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic add(input logic [7:0] b, input logic s, input logic e);
    stim.push_back({b, s, e});
  endtask

  task automatic add_hdr(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] len);
    add(ip[31:24], 1'b1, 1'b0);
    add(ip[23:16], 1'b0, 1'b0);
    add(ip[15:8], 1'b0, 1'b0);
    add(ip[7:0], 1'b0, 1'b0);
    add(port[15:8], 1'b0, 1'b0);
    add(port[7:0], 1'b0, 1'b0);
    add(len[15:8], 1'b0, 1'b0);
    add(len[7:0], 1'b0, 1'b0);
  endtask

  task automatic add_pay(input int n, input int mul, input int ofs);
    for (int i = 0; i < n; i++) add(8'(i * mul + ofs), 1'b0, 1'b0);
  endtask

  task automatic set_eop();
    stim[stim.size() - 1].e = 1'b1;
  endtask

  task automatic send();
    for (int i = 0; i < stim.size(); i++) drive(stim[i].b, stim[i].s, stim[i].e);
    stim.delete();
  endtask

  task automatic add_t1();
    add_hdr(32'hC0A80164, 16'h1388, 16'h000C);
    add_pay(12, 1, 1);
    set_eop();
  endtask

  task automatic exp_t1();
    exp_words.push_back(48'h010203040506);
    exp_words.push_back(48'h0708090A0B0C);
  endtask

  task automatic expect_pkt(input string tag, input int nd, input int ne);
    int got_w;
    idle(10);
    got_w = rx_words.size() - base_w;
    check({tag, "_word_count"}, 64'(got_w), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_w; i++)
      check({tag, "_word"}, 64'(rx_words[base_w + i]), 64'(exp_words[i]));
    check({tag, "_pkt_done"}, 64'(n_done - base_d), 64'(nd));
    check({tag, "_pkt_err"}, 64'(n_err - base_e), 64'(ne));
    exp_words.delete();
    snap();
  endtask

  initial begin
    int w;
    logic [47:0] wv;
    reset_n    = 1'b0;
    rx_byte    = 8'h00;
    rx_valid   = 1'b0;
    rx_sop     = 1'b0;
    rx_eop     = 1'b0;
    word_ready = 1'b1;
    #5;
    check("reset_rx_ready", 64'(rx_ready), 64'd1);
    check("reset_word_valid", 64'(word_valid), 64'd0);
    check("reset_src_ip", 64'(src_ip), 64'd0);
    check("reset_err_code", 64'(err_code), 64'd0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    snap();

    // T1: clean packet.
    add_t1();
    send();
    exp_t1();
    check("t1_hdr_valid", 64'(n_hdr - base_h), 64'd1);
    expect_pkt("t1", 1, 0);
    check("t1_src_ip", 64'(src_ip), 64'hC0A80164);
    check("t1_src_port", 64'(src_port), 64'h1388);
    check("t1_pkt_len", 64'(pkt_len), 64'h000C);

    // T2: downstream stalled while the first word waits.
    word_ready = 1'b0;
    add_t1();
    fork
      send();
      begin
        w = 0;
        @(negedge clk);
        while (!word_valid && w < 500) begin
          @(negedge clk);
          w++;
        end
        check("t2_first_word_valid", 64'(word_valid), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("t2_no_transfer_while_blocked", 64'(rx_words.size() - base_w), 64'd0);
        check("t2_rx_ready_low_on_0c", 64'(n_stall0c > base_s), 64'd1);
        word_ready = 1'b1;
      end
    join
    exp_t1();
    expect_pkt("t2", 1, 0);

    // T3: illegal lengths, then recovery.
    add_hdr(32'h0A000001, 16'h0001, 16'h0007);
    add_pay(7, 1, 0);
    set_eop();
    send();
    expect_pkt("t3_len7", 0, 1);
    check("t3_len7_code", 64'(err_code), 64'd1);
    check("t3_len7_pkt_len", 64'(pkt_len), 64'h0007);
    add_hdr(32'h0A000001, 16'h0001, 16'h0000);
    set_eop();
    send();
    expect_pkt("t3_len0", 0, 1);
    check("t3_len0_code", 64'(err_code), 64'd1);
    add_hdr(32'h0A000001, 16'h0001, 16'd1476);
    add_pay(1, 1, 0);
    set_eop();
    send();
    expect_pkt("t3_len1476", 0, 1);
    check("t3_len1476_code", 64'(err_code), 64'd1);
    add_t1();
    send();
    exp_t1();
    expect_pkt("t3_recover", 1, 0);

    // T4: truncated, then overlong.
    add_hdr(32'hC0A80164, 16'h1388, 16'h000C);
    add_pay(8, 1, 1);
    set_eop();
    send();
    exp_words.push_back(48'h010203040506);
    expect_pkt("t4_short", 0, 1);
    check("t4_short_code", 64'(err_code), 64'd2);
    add_hdr(32'hC0A80164, 16'h1388, 16'h0006);
    add_pay(9, 1, 1);
    set_eop();
    send();
    exp_words.push_back(48'h010203040506);
    expect_pkt("t4_long", 0, 1);
    check("t4_long_code", 64'(err_code), 64'd3);
    add_t1();
    send();
    exp_t1();
    expect_pkt("t4_recover", 1, 0);

    // T5: packet B starts on payload byte 3 of packet A.
    add_hdr(32'h01020304, 16'h0050, 16'h000C);
    add_pay(2, 1, 8'h11);
    add_hdr(32'hAC100005, 16'h2710, 16'h000C);
    add_pay(12, 1, 8'h21);
    set_eop();
    send();
    exp_words.push_back(48'h212223242526);
    exp_words.push_back(48'h2728292A2B2C);
    expect_pkt("t5", 1, 1);
    check("t5_code", 64'(err_code), 64'd2);
    check("t5_src_ip", 64'(src_ip), 64'hAC100005);
    check("t5_src_port", 64'(src_port), 64'h2710);

    // T6: reset mid-payload, then a max-length packet with input gaps.
    gaps = 1'b1;
    add_hdr(32'hC0A80164, 16'h1388, 16'h000C);
    add_pay(3, 1, 1);
    send();
    reset_n = 1'b0;
    #2;
    check("t6_async_src_ip", 64'(src_ip), 64'd0);
    check("t6_async_pkt_len", 64'(pkt_len), 64'd0);
    check("t6_async_rx_ready", 64'(rx_ready), 64'd1);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    snap();
    add_pay(9, 1, 4);
    set_eop();
    send();
    expect_pkt("t6_after_reset", 0, 0);
    add_hdr(32'hC0A80164, 16'h1388, 16'd1470);
    add_pay(1470, 7, 3);
    set_eop();
    send();
    for (int k = 0; k < 245; k++) begin
      wv = '0;
      for (int j = 0; j < 6; j++) wv = {wv[39:0], 8'((6 * k + j) * 7 + 3)};
      exp_words.push_back(wv);
    end
    expect_pkt("t6_max", 1, 0);
    check("t6_max_pkt_len", 64'(pkt_len), 64'd1470);
    check("never_done_and_err", 64'(n_both), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
